// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: CSR map, STATUS/CONTROL bit positions and THRESH reset value for uart_rx_fifo
package uart_rx_pkg;
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_THRESH = 2'd3;
  localparam int ST_EMPTY = 16;
  localparam int ST_FULL = 17;
  localparam int ST_OVERRUN = 18;
  localparam int ST_IRQ = 19;
  localparam int CTRL_FLUSH = 0;
  localparam int CTRL_CLR_OVR = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int DATA_VALID = 31;
  localparam logic [8:0] THRESH_RST = 9'd1;
endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// sync_fifo: power-of-two circular buffer with flush priority and push-while-full when popping
module sync_fifo #(
  parameter int DATA_W = 9,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_pop, do_push;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && !flush && (!full || do_pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: Avalon-MM UART receive FIFO with CSRs; irq port and logic present only under UART_RX_IRQ_EN
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int DATA_W = 9,
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [DATA_W-1:0] RX_data,
  input  logic              load
`ifdef UART_RX_IRQ_EN
  ,
  output logic              irq
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic rd, wr, pop, flush, ovr_clr, ovr_set, overrun, irq_en, irq_pending, full, empty;
  logic [DATA_W-1:0] dout;
  logic [CW-1:0] cnt;
  logic [8:0] count9, thresh;
  logic [31:0] status, rd_mux;
  assign rd = chipselect && read;
  assign wr = chipselect && write;
  assign pop = rd && address == ADDR_DATA;
  assign flush = wr && address == ADDR_CONTROL && writedata[CTRL_FLUSH];
  assign ovr_clr = wr && address == ADDR_CONTROL && writedata[CTRL_CLR_OVR];
  assign ovr_set = load && full && !pop && !flush;
  assign count9 = 9'(cnt);
  assign irq_pending = irq_en && (count9 >= thresh || overrun);
  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(reset),
    .push(load),
    .pop(pop),
    .flush(flush),
    .din(RX_data),
    .dout(dout),
    .count(cnt),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    status = '0;
    status[8:0] = count9;
    status[ST_EMPTY] = empty;
    status[ST_FULL] = full;
    status[ST_OVERRUN] = overrun;
    status[ST_IRQ] = irq_pending;
    rd_mux = address == ADDR_DATA ? (empty ? 32'd0 : ((32'd1 << DATA_VALID) | 32'(dout))) :
             address == ADDR_STATUS ? status :
             address == ADDR_CONTROL ? (32'(irq_en) << CTRL_IRQ_EN) :
             32'(thresh);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
      overrun <= 1'b0;
      thresh <= THRESH_RST;
    end else begin
      if (rd) readdata <= rd_mux;
      if (wr && address == ADDR_THRESH) thresh <= writedata[8:0];
      overrun <= (overrun && !ovr_clr) || ovr_set;
    end
  end
`ifdef UART_RX_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (wr && address == ADDR_CONTROL) irq_en <= writedata[CTRL_IRQ_EN];
      irq <= irq_pending;
    end
  end
`else
  assign irq_en = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed and randomized checks of uart_rx_fifo against a queue-based model
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  logic clk = 1'b0;
  logic reset, chipselect, read, write, load;
  logic [1:0] address;
  logic [31:0] writedata, readdata;
  logic [8:0] RX_data;
`ifdef UART_RX_IRQ_EN
  logic irq;
`endif
  int checks = 0;
  int errors = 0;
  logic [8:0] q [$];
  bit ovr, ien;
  logic [8:0] thr;
  logic [31:0] last_rd;

  uart_rx_fifo #(.DATA_W(9), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .chipselect(chipselect),
    .read(read),
    .write(write),
    .writedata(writedata),
    .readdata(readdata),
    .RX_data(RX_data),
    .load(load)
`ifdef UART_RX_IRQ_EN
    ,
    .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %08h expected %08h", tag, obs, expv);
    end
  endtask

  task automatic idle();
    load = 1'b0;
    chipselect = 1'b0;
    read = 1'b0;
    write = 1'b0;
    address = 2'd0;
    writedata = '0;
    RX_data = '0;
  endtask

  task automatic model_reset();
    q.delete();
    ovr = 1'b0;
    ien = 1'b0;
    thr = 9'd1;
    last_rd = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    bit pend;
    pend = ien && (q.size() >= int'(thr) || ovr);
    case (a)
      2'd0: return q.size() > 0 ? (32'h8000_0000 | 32'(q[0])) : 32'd0;
      2'd1: return {12'd0, pend, ovr, q.size() == DEPTH, q.size() == 0, 7'd0, 9'(q.size())};
      2'd2: return {29'd0, ien, 2'd0};
      default: return {23'd0, thr};
    endcase
  endfunction

  task automatic step(input bit ld, input logic [8:0] d, input bit r, input bit w,
                      input logic [1:0] a, input logic [31:0] wd);
    logic [31:0] expv;
    bit set;
    load = ld;
    RX_data = d;
    chipselect = r || w;
    read = r;
    write = w;
    address = a;
    writedata = wd;
    expv = model_read(a);
    set = 1'b0;
    @(posedge clk);
    if (r && a == 2'd0 && q.size() > 0) void'(q.pop_front());
    if (w && a == 2'd2 && wd[0]) q.delete();
    else if (ld) begin
      if (q.size() < DEPTH) q.push_back(d);
      else set = 1'b1;
    end
    ovr = (ovr && !(w && a == 2'd2 && wd[1])) || set;
`ifdef UART_RX_IRQ_EN
    if (w && a == 2'd2) ien = wd[2];
`endif
    if (w && a == 2'd3) thr = wd[8:0];
    if (r) last_rd = expv;
    #1;
    idle();
    chk(r ? "read" : "hold", readdata, last_rd);
  endtask

  task automatic do_load(input logic [8:0] d);
    step(1'b1, d, 1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic do_read(input logic [1:0] a);
    step(1'b0, 9'd0, 1'b1, 1'b0, a, 32'd0);
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] wd);
    step(1'b0, 9'd0, 1'b0, 1'b1, a, wd);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_readdata", readdata, 32'd0);
`ifdef UART_RX_IRQ_EN
    chk("reset_irq", 32'(irq), 32'd0);
`endif
    reset = 1'b0;
    do_read(2'd1);
    chk("reset_status", readdata, 32'h0001_0000);
    do_read(2'd3);
    chk("reset_thresh", readdata, 32'd1);
    do_read(2'd2);
    chk("reset_control", readdata, 32'd0);

    do_load(9'h054);
    do_read(2'd0);
    chk("single_read", readdata, 32'h8000_0054);
    do_read(2'd1);
    chk("single_status", readdata, 32'h0001_0000);

    for (int i = 0; i < 16; i++) do_load(9'(i));
    do_load(9'h12C);
    do_read(2'd1);
    chk("full_overrun_status", readdata, 32'h0006_0010);
    for (int i = 0; i < 16; i++) begin
      do_read(2'd0);
      chk("order", readdata, 32'h8000_0000 | 32'(i));
    end
    do_read(2'd0);
    chk("empty_read", readdata, 32'd0);
    do_write(2'd2, 32'h2);
    do_write(2'd0, 32'hFFFF_FFFF);
    do_write(2'd1, 32'hFFFF_FFFF);
    do_read(2'd1);
    chk("ovr_clear_ignored_writes", readdata, 32'h0001_0000);

    for (int i = 0; i < 16; i++) do_load(9'(32 + i));
    step(1'b1, 9'h1AA, 1'b1, 1'b0, 2'd0, 32'd0);
    chk("full_load_pop", readdata, 32'h8000_0020);
    do_read(2'd1);
    chk("full_load_pop_status", readdata, 32'h0002_0010);
    for (int i = 0; i < 16; i++) do_read(2'd0);
    chk("last_out", readdata, 32'h8000_01AA);

    step(1'b1, 9'h0A5, 1'b1, 1'b0, 2'd0, 32'd0);
    chk("empty_load_read", readdata, 32'd0);
    do_read(2'd0);
    chk("empty_load_stored", readdata, 32'h8000_00A5);

    for (int i = 0; i < 3; i++) do_load(9'(i + 5));
    step(1'b1, 9'h077, 1'b0, 1'b1, 2'd2, 32'h1);
    do_read(2'd1);
    chk("flush_status", readdata, 32'h0001_0000);
    do_read(2'd0);
    chk("flush_read", readdata, 32'd0);

`ifdef UART_RX_IRQ_EN
    do_write(2'd3, 32'd4);
    do_write(2'd2, 32'h4);
    for (int i = 0; i < 4; i++) do_load(9'(i + 1));
    step(1'b0, 9'd0, 1'b0, 1'b0, 2'd0, 32'd0);
    chk("irq_set", 32'(irq), 32'd1);
    do_read(2'd0);
    step(1'b0, 9'd0, 1'b0, 1'b0, 2'd0, 32'd0);
    chk("irq_clear", 32'(irq), 32'd0);
    do_write(2'd2, 32'h1);
    do_write(2'd3, 32'd1);
`endif

    for (int n = 0; n < 500; n++) begin
      bit r, w, ld;
      logic [1:0] a;
      logic [31:0] wd;
      r = ($urandom % 3) == 0;
      w = !r && ($urandom % 6) == 0;
      a = r ? 2'($urandom % 4) : (($urandom % 2) != 0 ? 2'd2 : 2'd3);
      if (w && ($urandom % 5) == 0) a = 2'($urandom % 2);
      wd = a == 2'd2 ? (32'($urandom % 8) & ((($urandom % 8) == 0) ? 32'd7 : 32'd6)) : 32'($urandom % 24);
      ld = ($urandom % 2) != 0;
      step(ld, 9'($urandom % 512), r, w, a, wd);
      if (n % 10 == 9) do_read(2'd1);
    end

    do_write(2'd2, 32'h1);
    for (int i = 0; i < 17; i++) do_load(9'(i + 64));
    for (int i = 0; i < 11; i++) do_read(2'd0);
    do_read(2'd1);
    chk("pre_reset_status", readdata, 32'h0004_0005);
    reset = 1'b1;
    load = 1'b1;
    RX_data = 9'h033;
    chipselect = 1'b1;
    read = 1'b1;
    address = 2'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle();
    model_reset();
    chk("midop_reset_readdata", readdata, 32'd0);
    do_read(2'd1);
    chk("midop_reset_status", readdata, 32'h0001_0000);
    do_read(2'd0);
    chk("midop_reset_data", readdata, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter DATA_W, default 9, meaning the received-word width (8 data bits plus 1 frame-error bit).
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning the FIFO entry count; it SHALL be a power of two, 2..256.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: the synchronous, active-high reset.
REQ-005 The block SHALL have port address, input, 2 bits: the CSR select (0 DATA, 1 STATUS, 2 CONTROL, 3 THRESH).
REQ-006 The block SHALL have ports chipselect, read and write, each input, 1 bit: the Avalon-MM slave strobes.
REQ-007 The block SHALL have port writedata, input, 32 bits: the CSR write data.
REQ-008 The block SHALL have port readdata, output, 32 bits: the CSR read data, registered.
REQ-009 The block SHALL have port RX_data, input, DATA_W bits: the received word from the UART receiver.
REQ-010 The block SHALL have port load, input, 1 bit: a one-cycle pulse that pushes RX_data.
REQ-011 The block SHALL have port irq, output, 1 bit: the interrupt request, present only under UART_RX_IRQ_EN.

Function
REQ-012 An access SHALL be accepted when chipselect=1 and read or write=1; readdata SHALL update at that edge (read latency 1) and hold until the next read.
REQ-013 A DATA read with the FIFO non-empty SHALL return {bit31=1, zeros, head word in [DATA_W-1:0]} and pop the head at the same edge.
REQ-014 A DATA read with the FIFO empty SHALL return 0 and leave the pointers unchanged.
REQ-015 A STATUS read SHALL return [8:0] count, [16] empty, [17] full, [18] overrun, [19] irq_pending; all other bits SHALL be 0.
REQ-016 A CONTROL write SHALL act as follows: bit0=1 flushes the FIFO (count←0, pointers←0); bit1=1 clears overrun; bit2 is stored as irq_en.
REQ-017 A CONTROL read SHALL return irq_en in bit2 and 0 elsewhere.
REQ-018 A THRESH write SHALL store writedata[8:0]; a THRESH read SHALL return it.
REQ-019 A load with the FIFO not full SHALL write RX_data at the tail; count increments.
REQ-020 A load with the FIFO full and no same-cycle pop SHALL drop the word and set sticky overrun.
REQ-021 A load and a DATA pop in the same cycle SHALL both take effect and leave count unchanged; when full, no overrun SHALL be set.
REQ-022 A load and a DATA read in the same cycle with the FIFO empty SHALL return 0 to the read and store the word.
REQ-023 Flush and load in the same cycle SHALL give flush priority; the word SHALL be dropped and overrun left unchanged.
REQ-024 Pointers SHALL wrap modulo DEPTH; count SHALL saturate at neither end, because REQ-014 and REQ-020 prevent it.
REQ-025 Writes to DATA or STATUS SHALL be ignored.

Reset
REQ-026 While reset=1 the block SHALL force readdata=0, count=0, pointers=0, overrun=0, irq_en=0, THRESH=1 and irq=0; storage contents are don't-care.
REQ-027 Reset asserted mid-operation SHALL discard all entries and any access in that cycle.

Configuration
REQ-028 When UART_RX_IRQ_EN is defined, irq SHALL be registered and equal irq_en AND (count ≥ THRESH OR overrun), updating one cycle after the causing event.
REQ-029 When UART_RX_IRQ_EN is undefined, the irq port and the irq logic SHALL be absent, CONTROL bit2 SHALL read 0, and STATUS bit19 SHALL read 0.

Structure
REQ-030 Package uart_rx_pkg SHALL hold the CSR address constants, the STATUS and CONTROL bit positions, and the THRESH reset value.
REQ-031 Storage and pointers SHALL live in the sub-module sync_fifo (parameters DATA_W and DEPTH; ports push, pop, flush, din, dout, count, full, empty).

Verification
REQ-032 The bench SHALL cover: reset, load RX_data=0x054, DATA read → readdata=0x80000054 next cycle; STATUS count=0, empty=1.
REQ-033 The bench SHALL cover: 16 loads of 0x000..0x00F plus 1 extra load (0x12C) → full=1, overrun=1; 16 reads return 0x000..0x00F in order; the 17th read → 0.
REQ-034 The bench SHALL cover: FIFO full, simultaneous load 0x1AA and DATA read → the head is returned, count stays 16, overrun stays 0, and 0x1AA is last out.
REQ-035 The bench SHALL cover: 3 entries, CONTROL write 0x1 in the same cycle as a load → count=0, empty=1; next DATA read → 0.
REQ-036 The bench SHALL cover, with UART_RX_IRQ_EN defined: THRESH=4, CONTROL=0x4, 4 loads → irq=1 one cycle after the 4th; one DATA read → irq=0.
REQ-037 The bench SHALL cover: reset asserted with 5 entries and overrun set → all status cleared and readdata=0 on the following cycle.
